bus_word_serializer: RTL and testbench

Accepts a BUS_SIZE-bit bus word-parallel through a valid/ready handshake. Splits it into WORD_NUM words of WORD_SIZE bits and emits them one word per cycle on a valid/ready output stream. Word order is selected per bus by a mode input: LSB-word first, or reversed (MSB-word first). An optional mode drops all-zero words, and a latched per-word nonzero mask is presented as control. It sits between bus-wide producers and word-wide consumers in the datapath.

---
 rtl/bus_word_serializer.sv | 83 ++++++++
 tb/tb_bus_word_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_word_serializer.sv
// bus_word_serializer: splits an accepted bus into words emitted one per cycle, optionally skipping zero words
// Ports: clk, reset (async active-low); in_valid/in_ready/data_in/order accept a bus;
//        out_valid/out_ready/data_out/out_index/out_last stream words; control = nonzero mask of last accepted bus
module bus_word_serializer #(
  parameter int BUS_SIZE = 16,
  parameter int WORD_SIZE = 4,
  parameter int IDX_W = 2,
  parameter int SKIP_ZERO = 0,
  localparam int WORD_NUM = BUS_SIZE / WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_SIZE-1:0]  data_in,
  input  logic                 order,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_last,
  output logic [WORD_NUM-1:0]  control
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [BUS_SIZE-1:0] buf_q;
  logic ord_q, accept, first_found, next_found;
  logic [IDX_W-1:0] idx_q, idx_d, first_idx, next_idx;
  logic [WORD_NUM-1:0] nz_in, ok_in, ok_q;
  // Nearest emittable word at or beyond 'from' in the given direction (dir=1 descending); MSB = found
  function automatic logic [IDX_W:0] scan(input logic [WORD_NUM-1:0] ok, input logic dir, input int from);
    logic [IDX_W:0] r;
    int a;
    r = '0;
    for (int k = 0; k < WORD_NUM; k++) begin
      a = dir ? k : WORD_NUM - 1 - k;
      if (ok[a] && (dir ? a <= from : a >= from)) r = {1'b1, IDX_W'(a)};
    end
    return r;
  endfunction
  always_comb begin
    nz_in = '0;
    for (int k = 0; k < WORD_NUM; k++) nz_in[k] = |data_in[k*WORD_SIZE +: WORD_SIZE];
    // control always mirrors the latched bus, so it doubles as the skip mask while shifting
    ok_in = SKIP_ZERO != 0 ? nz_in : '1;
    ok_q = SKIP_ZERO != 0 ? control : '1;
    {first_found, first_idx} = scan(ok_in, order, order ? WORD_NUM - 1 : 0);
    {next_found, next_idx} = scan(ok_q, ord_q, ord_q ? int'(idx_q) - 1 : int'(idx_q) + 1);
    in_ready = reset && state_q == IDLE;
    out_valid = state_q == SHIFT;
    out_last = out_valid && !next_found;
    data_out = out_valid ? buf_q[idx_q*WORD_SIZE +: WORD_SIZE] : '0;
    out_index = out_valid ? idx_q : '0;
    accept = in_valid && in_ready;
    state_d = state_q;
    idx_d = idx_q;
    if (accept) begin
      state_d = first_found ? SHIFT : IDLE;
      idx_d = first_idx;
    end
    if (out_valid && out_ready) begin
      state_d = next_found ? SHIFT : IDLE;
      idx_d = next_found ? next_idx : idx_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      buf_q <= '0;
      ord_q <= 1'b0;
      control <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (accept) begin
        buf_q <= data_in;
        ord_q <= order;
        control <= nz_in;
      end
    end
  end
endmodule

// File: tb/tb_bus_word_serializer.sv
// tb_bus_word_serializer: scoreboard bench for plain and zero-skipping serializers
module tb_bus_word_serializer;
  localparam int BS = 16, WS = 4, WN = 4;
  typedef struct packed {logic [WS-1:0] d; logic [1:0] i; logic l;} exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid [2], in_ready [2], order [2], out_valid [2], out_ready [2], out_last [2];
  logic [BS-1:0] data_in [2];
  logic [WS-1:0] data_out [2];
  logic [1:0] out_index [2];
  logic [WN-1:0] control [2];
  logic [WN-1:0] exp_ctrl [2];
  logic held [2], after_last [2];
  exp_t hold_e [2];
  exp_t q0[$], q1[$];
  int rmode [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bus_word_serializer #(.BUS_SIZE(BS), .WORD_SIZE(WS), .IDX_W(2), .SKIP_ZERO(0)) u0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .data_in(data_in[0]),
    .order(order[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0]),
    .out_index(out_index[0]), .out_last(out_last[0]), .control(control[0]));
  bus_word_serializer #(.BUS_SIZE(BS), .WORD_SIZE(WS), .IDX_W(2), .SKIP_ZERO(1)) u1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .data_in(data_in[1]),
    .order(order[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1]),
    .out_index(out_index[1]), .out_last(out_last[1]), .control(control[1]));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [WN-1:0] mask(input logic [BS-1:0] d);
    logic [WN-1:0] m;
    for (int k = 0; k < WN; k++) m[k] = d[k*WS +: WS] != 0;
    return m;
  endfunction
  // Reference: walk words in the selected direction, drop zeros for the skipping instance, flag the final one
  task automatic model(input int s, input logic [BS-1:0] d, input logic o, output int n);
    exp_t l[$];
    exp_t e;
    int k;
    for (int j = 0; j < WN; j++) begin
      k = o ? WN - 1 - j : j;
      e.d = d[k*WS +: WS];
      e.i = 2'(k);
      e.l = 1'b0;
      if (!(s == 1 && e.d == 0)) l.push_back(e);
    end
    n = l.size();
    if (n > 0) begin
      e = l.pop_back();
      e.l = 1'b1;
      l.push_back(e);
    end
    foreach (l[j]) if (s == 0) q0.push_back(l[j]); else q1.push_back(l[j]);
  endtask
  task automatic mon(input int s);
    exp_t a, e;
    logic empty;
    a = {data_out[s], out_index[s], out_last[s]};
    if (!rst_n) return;
    chk($sformatf("control%0d", s), control[s], exp_ctrl[s]);
    if (after_last[s]) begin
      chk($sformatf("in_ready after last%0d", s), in_ready[s], 1);
      chk($sformatf("idle after last%0d", s), out_valid[s], 0);
      after_last[s] = 0;
    end
    if (held[s]) begin
      chk($sformatf("stall valid%0d", s), out_valid[s], 1);
      chk($sformatf("stall hold%0d", s), a, hold_e[s]);
      held[s] = 0;
    end
    if (out_valid[s]) begin
      if (out_ready[s]) begin
        empty = s == 0 ? q0.size() == 0 : q1.size() == 0;
        if (empty) begin
          checks++;
          failures++;
          $display("FAIL unexpected word%0d: got %0h expected none", s, a);
        end else begin
          e = s == 0 ? q0.pop_front() : q1.pop_front();
          chk($sformatf("word%0d", s), a, e);
          if (e.l) after_last[s] = 1;
        end
      end else begin
        held[s] = 1;
        hold_e[s] = a;
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  initial forever begin
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++)
      if (rmode[s] == 0) out_ready[s] = 1'($urandom % 2);
      else if (rmode[s] == 1) out_ready[s] = 1'b1;
  end
  function automatic logic [BS-1:0] rnd_bus();
    logic [BS-1:0] d;
    if ($urandom % 8 == 0) return '0;
    for (int k = 0; k < WN; k++) d[k*WS +: WS] = ($urandom % 3 == 0) ? '0 : WS'($urandom);
    return d;
  endfunction
  // Offers buses until n are accepted; data and order change every cycle so only the accepted value may matter
  task automatic xfer(input int s, input int n, input bit full, input bit fixed, input logic [BS-1:0] fd, input logic fo);
    int acc = 0, cyc = 0, cnt = 0;
    bit took;
    logic [WN-1:0] m = '0;
    while (acc < n && cyc < 5000) begin
      cyc++;
      in_valid[s] = fixed || full ? 1'b1 : 1'($urandom % 2);
      data_in[s] = fixed ? fd : rnd_bus();
      order[s] = fixed ? fo : 1'($urandom % 2);
      took = 0;
      @(negedge clk);
      if (in_valid[s] && in_ready[s]) begin
        model(s, data_in[s], order[s], cnt);
        m = mask(data_in[s]);
        acc++;
        took = 1;
      end
      @(posedge clk);
      #1;
      if (took) begin
        exp_ctrl[s] = m;
        chk($sformatf("control load%0d", s), control[s], m);
        chk($sformatf("first latency%0d", s), out_valid[s], cnt > 0);
      end
    end
    in_valid[s] = 1'b0;
    if (acc < n) begin
      checks++;
      failures++;
      $display("FAIL accept timeout%0d: got %0d expected %0d", s, acc, n);
    end
  endtask
  task automatic drain();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (cyc < 2000 && (q0.size() != 0 || q1.size() != 0 || out_valid[0] || out_valid[1]));
    if (cyc >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string n, input int s);
    chk({n, " valid"}, out_valid[s], 0);
    chk({n, " data"}, data_out[s], 0);
    chk({n, " index"}, out_index[s], 0);
    chk({n, " last"}, out_last[s], 0);
    chk({n, " control"}, control[s], 0);
    chk({n, " in_ready"}, in_ready[s], 0);
  endtask
  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 0;
      data_in[s] = '0;
      order[s] = 0;
      out_ready[s] = 1;
      rmode[s] = 1;
      exp_ctrl[s] = '0;
      held[s] = 0;
      after_last[s] = 0;
    end
    #2;
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    xfer(0, 1, 1, 1, 16'hA3C5, 0);
    drain();
    xfer(0, 1, 1, 1, 16'hA3C5, 1);
    drain();
    rmode[0] = 2;
    out_ready[0] = 1;
    xfer(0, 1, 1, 1, 16'hA3C5, 0);
    @(posedge clk);
    #1;
    out_ready[0] = 0;
    chk("stall data", data_out[0], 4'hC);
    chk("stall index", out_index[0], 1);
    repeat (3) @(posedge clk);
    #1;
    out_ready[0] = 1;
    drain();
    rmode[0] = 1;
    xfer(1, 1, 1, 1, 16'h0B00, 0);
    drain();
    xfer(1, 1, 1, 1, 16'h0000, 0);
    chk("zero bus in_ready", in_ready[1], 1);
    drain();
    xfer(0, 1, 1, 1, 16'hA3C5, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk_zero("abort0", 0);
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      exp_ctrl[s] = '0;
      held[s] = 0;
      after_last[s] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    xfer(0, 1, 1, 1, 16'h1234, 0);
    drain();
    rmode[0] = 0;
    rmode[1] = 0;
    xfer(0, 10, 1, 0, '0, 0);
    drain();
    xfer(1, 10, 1, 0, '0, 0);
    drain();
    xfer(0, 40, 0, 0, '0, 0);
    drain();
    xfer(1, 40, 0, 0, '0, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
